// File: rtl/sys_load_seq.sv
// sys_load_seq: load sequencer for the systolic array.
// Streams host elements into the weight and input memories and issues the
// start_load_weight / start_load_input pulses to sys_top. Optional weight
// reuse, N input vectors per run, and a programmable settle gap after each
// start pulse.
module sys_load_seq #(
    parameter int ELEMENT_BITS = 8,
    parameter int FEATURE_BITS = 4,
    parameter int W_DEPTH      = 81,
    parameter int I_DEPTH      = 4,
    parameter int VEC_BITS     = 4,
    parameter int WEIGHT_WAIT  = 200,
    parameter int INPUT_WAIT   = 200
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic                      abort,
    input  logic [VEC_BITS-1:0]       cfg_n_vec,
    input  logic                      cfg_reload_w,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [ELEMENT_BITS-1:0]   s_data,
    output logic                      wf_we,
    output logic [2*FEATURE_BITS-1:0] wf_add,
    output logic [ELEMENT_BITS-1:0]   wf_data,
    output logic                      if_we,
    output logic [FEATURE_BITS-1:0]   if_add,
    output logic [ELEMENT_BITS-1:0]   if_data,
    output logic                      start_load_weight,
    output logic                      start_load_input,
    output logic                      busy,
    output logic                      done,
    output logic                      go_err
);

    localparam int WA_BITS   = 2 * FEATURE_BITS;
    localparam int MAX_WAIT  = (WEIGHT_WAIT > INPUT_WAIT) ? WEIGHT_WAIT : INPUT_WAIT;
    localparam int WAIT_BITS = $clog2(MAX_WAIT) + 1;

    localparam logic [WA_BITS-1:0]      W_LAST      = WA_BITS'(W_DEPTH - 1);
    localparam logic [FEATURE_BITS-1:0] I_LAST      = FEATURE_BITS'(I_DEPTH - 1);
    localparam logic [WAIT_BITS-1:0]    W_WAIT_LAST = WAIT_BITS'(WEIGHT_WAIT - 1);
    localparam logic [WAIT_BITS-1:0]    I_WAIT_LAST = WAIT_BITS'(INPUT_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WFILL  = 3'd1,
        WSTART = 3'd2,
        WWAIT  = 3'd3,
        IFILL  = 3'd4,
        ISTART = 3'd5,
        IWAIT  = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t state, state_next;

    // Sequencing counters and the configuration captured when a run starts.
    logic [WA_BITS-1:0]      wcnt, wcnt_next;
    logic [FEATURE_BITS-1:0] icnt, icnt_next;
    logic [VEC_BITS-1:0]     vcnt, vcnt_next;
    logic [WAIT_BITS-1:0]    tcnt, tcnt_next;
    logic [VEC_BITS-1:0]     n_vec, n_vec_next;
    logic                    reload_w, reload_w_next;

    // Next values of the registered outputs.
    logic                    wf_we_next;
    logic [WA_BITS-1:0]      wf_add_next;
    logic [ELEMENT_BITS-1:0] wf_data_next;
    logic                    if_we_next;
    logic [FEATURE_BITS-1:0] if_add_next;
    logic [ELEMENT_BITS-1:0] if_data_next;
    logic                    slw_next;
    logic                    sli_next;
    logic                    done_next;
    logic                    go_err_next;

    logic beat;

    // The host handshake is a pure decode of the state register so that
    // s_ready never depends combinationally on s_valid.
    assign s_ready = (state == WFILL) || (state == IFILL);
    assign busy    = (state != IDLE);
    assign beat    = s_valid && s_ready;

    // State register plus all counters and registered outputs; reset clears everything.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            wcnt              <= '0;
            icnt              <= '0;
            vcnt              <= '0;
            tcnt              <= '0;
            n_vec             <= '0;
            reload_w          <= 1'b0;
            wf_we             <= 1'b0;
            wf_add            <= '0;
            wf_data           <= '0;
            if_we             <= 1'b0;
            if_add            <= '0;
            if_data           <= '0;
            start_load_weight <= 1'b0;
            start_load_input  <= 1'b0;
            done              <= 1'b0;
            go_err            <= 1'b0;
        end else begin
            state             <= state_next;
            wcnt              <= wcnt_next;
            icnt              <= icnt_next;
            vcnt              <= vcnt_next;
            tcnt              <= tcnt_next;
            n_vec             <= n_vec_next;
            reload_w          <= reload_w_next;
            wf_we             <= wf_we_next;
            wf_add            <= wf_add_next;
            wf_data           <= wf_data_next;
            if_we             <= if_we_next;
            if_add            <= if_add_next;
            if_data           <= if_data_next;
            start_load_weight <= slw_next;
            start_load_input  <= sli_next;
            done              <= done_next;
            go_err            <= go_err_next;
        end
    end

    // Next-state and next-output logic; abort outside IDLE overrides the whole run.
    always_comb begin
        state_next    = state;
        wcnt_next     = wcnt;
        icnt_next     = icnt;
        vcnt_next     = vcnt;
        tcnt_next     = tcnt;
        n_vec_next    = n_vec;
        reload_w_next = reload_w;
        wf_we_next    = 1'b0;
        wf_add_next   = wf_add;
        wf_data_next  = wf_data;
        if_we_next    = 1'b0;
        if_add_next   = if_add;
        if_data_next  = if_data;
        slw_next      = 1'b0;
        sli_next      = 1'b0;
        done_next     = 1'b0;
        go_err_next   = 1'b0;

        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            wcnt_next  = '0;
            icnt_next  = '0;
            vcnt_next  = '0;
            tcnt_next  = '0;
        end else begin
            if (go && (state != IDLE)) begin
                go_err_next = 1'b1;
            end

            case (state)
                IDLE: begin
                    if (go && !abort) begin
                        n_vec_next    = cfg_n_vec;
                        reload_w_next = cfg_reload_w;
                        wcnt_next     = '0;
                        icnt_next     = '0;
                        vcnt_next     = '0;
                        tcnt_next     = '0;
                        if (cfg_n_vec == '0) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else if (cfg_reload_w) begin
                            state_next = WFILL;
                        end else begin
                            state_next = IFILL;
                        end
                    end
                end

                WFILL: begin
                    if (beat) begin
                        wf_we_next   = 1'b1;
                        wf_add_next  = wcnt;
                        wf_data_next = s_data;
                        if (wcnt == W_LAST) begin
                            wcnt_next  = '0;
                            state_next = WSTART;
                        end else begin
                            wcnt_next = wcnt + WA_BITS'(1);
                        end
                    end
                end

                WSTART: begin
                    slw_next   = 1'b1;
                    tcnt_next  = '0;
                    state_next = WWAIT;
                end

                WWAIT: begin
                    if (tcnt == W_WAIT_LAST) begin
                        tcnt_next  = '0;
                        icnt_next  = '0;
                        state_next = IFILL;
                    end else begin
                        tcnt_next = tcnt + WAIT_BITS'(1);
                    end
                end

                IFILL: begin
                    if (beat) begin
                        if_we_next   = 1'b1;
                        if_add_next  = icnt;
                        if_data_next = s_data;
                        if (icnt == I_LAST) begin
                            icnt_next  = '0;
                            state_next = ISTART;
                        end else begin
                            icnt_next = icnt + FEATURE_BITS'(1);
                        end
                    end
                end

                ISTART: begin
                    sli_next   = 1'b1;
                    vcnt_next  = vcnt + VEC_BITS'(1);
                    tcnt_next  = '0;
                    state_next = IWAIT;
                end

                IWAIT: begin
                    if (tcnt == I_WAIT_LAST) begin
                        tcnt_next = '0;
                        if (vcnt == n_vec) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else begin
                            icnt_next  = '0;
                            state_next = IFILL;
                        end
                    end else begin
                        tcnt_next = tcnt + WAIT_BITS'(1);
                    end
                end

                DONE: begin
                    state_next = IDLE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
